// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param: oversampling UART receiver with configurable data width, parity and stop bits.
// Each bit is decided by a 3-sample majority vote centred on the bit midpoint.
module uart_rx_param #(
    parameter int CLK_DIV   = 16,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OS_W  = $clog2(OVS);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_PRE    = OS_W'(OVS / 2 - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVS / 2);
    localparam logic [OS_W-1:0]  OS_POST   = OS_W'(OVS / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [DIV_W-1:0]     w_div_next;
    logic                 r_tick;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_ferr_acc;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 w_vote;
    logic                 w_vote_tick;
    logic                 w_last_tick;
    logic                 w_deliver;
    logic                 w_busy;

    // Reset to the idle level so a reset can never look like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Tick is registered from the next count so it reads 0 during reset, even with CLK_DIV=1.
    assign w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_tick    <= (w_div_next == DIV_LAST);
        end
    end

    assign w_vote_tick = r_tick && (r_os_cnt == OS_POST);
    assign w_last_tick = r_tick && (r_os_cnt == OS_LAST);
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_tick && !r_sync2) w_state_next = S_START;
            end
            S_START: begin
                if (w_vote_tick && w_vote) w_state_next = S_IDLE;
                else if (w_last_tick)      w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_last_tick && (r_bit_cnt == DATA_LAST))
                    w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_last_tick) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_vote_tick && (r_bit_cnt == STOP_LAST))
                    w_state_next = (r_ferr_acc || !w_vote) ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (r_tick && r_sync2) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_deliver = (r_state == S_STOP) && w_vote_tick && (r_bit_cnt == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if (r_tick && (r_os_cnt == OS_PRE)) r_s0 <= r_sync2;
            if (r_tick && (r_os_cnt == OS_MID)) r_s1 <= r_sync2;

            if ((r_state == S_IDLE) || (r_state == S_WAIT_HIGH))
                r_os_cnt <= '0;
            else if (r_tick)
                r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);

            // bit_cnt counts data bits in DATA and stop bits in STOP.
            case (r_state)
                S_DATA: begin
                    if (w_last_tick)
                        r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
                end
                S_STOP: begin
                    if (w_last_tick) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                end
                default: r_bit_cnt <= '0;
            endcase

            if ((r_state == S_DATA) && w_vote_tick)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};

            if (r_state == S_START) begin
                r_par_err  <= 1'b0;
                r_ferr_acc <= 1'b0;
            end

            if ((r_state == S_PARITY) && w_vote_tick)
                r_par_err <= (PARITY == 1) ? ~((^r_shift) ^ w_vote) : ((^r_shift) ^ w_vote);

            if ((r_state == S_STOP) && w_vote_tick)
                r_ferr_acc <= r_ferr_acc | ~w_vote;

            if (w_deliver) begin
                r_data       <= r_shift;
                r_valid      <= 1'b1;
                r_parity_err <= (PARITY != 0) && r_par_err;
                r_frame_err  <= r_ferr_acc | ~w_vote;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = w_busy;
    assign tick       = r_tick;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next generation of the fixed 8N1 receiver in the UART visualisation path. It takes the asynchronous serial line, synchronises it, and oversamples each bit with a majority-vote midpoint. It supports configurable data width, parity and stop bits. Each received character is delivered as a parallel word with a one-cycle `valid` strobe and per-character parity and framing error flags, for the display/decoder logic downstream.

## Interface
- `CLK_DIV`, 16: clk cycles per oversample tick (≥1); baud = f_clk / (CLK_DIV·OVS).
- `OVS`, 16: oversample ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data bits per character, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rxd` in 1: asynchronous serial line, idle high.
- `data` out DATA_BITS: last received character.
- `valid` out 1: one-cycle strobe; `data`/errors updated this cycle.
- `parity_err` out 1: parity mismatch for the current `data`; held until the next `valid`.
- `frame_err` out 1: a stop bit sampled low for the current `data`; held until the next `valid`.
- `busy` out 1: high in every state except IDLE.
- `tick` out 1: oversample strobe, one cycle every CLK_DIV cycles.

## Operation
- Synchroniser: 2 flops on `rxd` produce `rxd_s`. Reset value is 1 (idle line), so reset never produces a false start.
- Tick generator: free-running counter 0..CLK_DIV-1, `tick` = (count == CLK_DIV-1). With CLK_DIV=1, `tick` is constant 1 after reset.
- Oversample counter `os_cnt` is $clog2(OVS) wide and advances only on `tick`. Bit counter `bit_cnt` is $clog2(DATA_BITS) wide.
- Vote: majority of the `rxd_s` samples at ticks with `os_cnt` = OVS/2-1, OVS/2 and OVS/2+1. The bit decision is made on the OVS/2+1 tick.
- States:
  - IDLE: on a tick with `rxd_s`=0, go to START with `os_cnt`=0.
  - START: if the vote = 1, treat it as a glitch and return to IDLE at the vote tick. Otherwise, at `os_cnt`=OVS-1 go to DATA with `os_cnt` and `bit_cnt` = 0.
  - DATA: the vote is shifted into the MSB of the shift register (LSB-first arrival). At `os_cnt`=OVS-1, advance `bit_cnt`. After bit DATA_BITS-1, go to PARITY if PARITY≠0, else STOP.
  - PARITY: the vote is compared with the XOR of the data bits. For odd parity, the total count of ones (data plus parity) must be odd; for even parity, it must be even.
  - STOP: one or two stop bits. At the vote of the last stop bit, load `data`, pulse `valid`, and set `parity_err`/`frame_err`. If no frame error, go to IDLE immediately on that cycle, leaving half a bit of resynchronisation margin. If there is a frame error, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with `rxd_s`=1, then go to IDLE. A break or held-low line therefore yields exactly one character.
- `frame_err` is set if any stop-bit vote is 0. `parity_err` is always 0 when PARITY=0. `data` is delivered even when flags are set.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `tick`=0, state = IDLE, all counters 0.
- Start detection latency: 2 cycles (synchroniser) plus up to CLK_DIV cycles of tick alignment.
- `valid` asserts on the cycle after the clock edge where the last stop-bit vote tick is registered. It is exactly one cycle wide and never occurs on two consecutive cycles.
- `rst` mid-frame: the next cycle is IDLE with all outputs at their reset values, and the partial character is discarded.
- Back-to-back frames with zero idle time are received without loss.
- Start-bit glitch shorter than 2 ticks: no `valid`, `busy` returns low.

## Test plan
- CLK_DIV=4, OVS=16, 8N1; send 0xA5, then 0x3C back-to-back, bit period 64 clk -> two `valid` pulses with `data`=0xA5 then 0x3C, both errors 0.
- PARITY=2, send 0x07 with parity bit 1 (correct) then 0x07 with parity bit 0 -> `parity_err`=0 then 1, `data`=0x07 both times.
- Stop bit forced low on 0x55, line held low for 3 frame times -> exactly one `valid`, `data`=0x55, `frame_err`=1, `busy` stays high until the line returns high.
- `rxd` low pulse of 1 tick (4 clk) -> `busy` pulses high then low, no `valid`.
- Assert `rst` during data bit 4 of a frame, release, send 0x81 -> no spurious `valid`, then `data`=0x81.
- DATA_BITS=7, STOP_BITS=2, PARITY=1, CLK_DIV=1; send 0x41 with baud skewed ±3% -> `data`=0x41, no errors.
